// File: rtl/fb_fill_writer.sv
// fb_fill_writer: fills a clamped rectangle of a linear framebuffer with one colour
module fb_fill_writer #(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ADDR_BITS = 19
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [9:0]           cmd_x0,
    input  logic [8:0]           cmd_y0,
    input  logic [9:0]           cmd_x1,
    input  logic [8:0]           cmd_y1,
    input  logic [2:0]           cmd_rgb,
    output logic                 fb_we,
    input  logic                 fb_stall,
    output logic [ADDR_BITS-1:0] fb_write_addr,
    output logic                 fb_red,
    output logic                 fb_green,
    output logic                 fb_blue,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
);
    typedef enum logic [1:0] {IDLE, CHECK, FILL, FINISH} state_t;
    localparam logic [9:0]           X_MAX = 10'(H_RES - 1);
    localparam logic [8:0]           Y_MAX = 9'(V_RES - 1);
    localparam logic [ADDR_BITS-1:0] ROW   = ADDR_BITS'(H_RES);
    state_t                 state, state_nxt;
    logic [9:0]             x0, x1, x, x1c;
    logic [8:0]             y0, y1, y, y1c;
    logic [2:0]             rgb;
    logic                   err, rej, consume, last_x, last_y;
    logic [ADDR_BITS-1:0]   addr, row_base, start_base;

    // constant multiply by H_RES built from shifted copies of the row index
    function automatic logic [ADDR_BITS-1:0] row_of(input logic [8:0] r);
        logic [ADDR_BITS-1:0] acc;
        acc = '0;
        for (int i = 0; i < 31; i++)
            if (((H_RES >> i) & 1) != 0) acc = acc + (ADDR_BITS'(r) << i);
        return acc;
    endfunction

    assign x1c        = (x1 > X_MAX) ? X_MAX : x1;
    assign y1c        = (y1 > Y_MAX) ? Y_MAX : y1;
    assign rej        = (x0 > X_MAX) || (y0 > Y_MAX) || (x0 > x1c) || (y0 > y1c);
    assign start_base = row_of(y0);
    assign last_x     = (x == x1);
    assign last_y     = (y == y1);
    assign consume    = (state == FILL) && !fb_stall;

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign fb_we         = (state == FILL);
    assign done          = (state == FINISH);
    assign cmd_err       = (state == FINISH) && err;
    assign fb_write_addr = addr;
    assign {fb_red, fb_green, fb_blue} = rgb;

    // state register; reset aborts any fill immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = cmd_valid ? CHECK : IDLE;
            CHECK:   state_nxt = rej ? FINISH : FILL;
            FILL:    state_nxt = (consume && last_x && last_y) ? FINISH : FILL;
            default: state_nxt = IDLE;
        endcase
    end

    // command capture, clamping and raster walk; everything holds while stalled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x0 <= '0; y0 <= '0; x1 <= '0; y1 <= '0; rgb <= '0; err <= 1'b0;
            x <= '0; y <= '0; addr <= '0; row_base <= '0;
        end else if (state == IDLE && cmd_valid) begin
            x0 <= cmd_x0; y0 <= cmd_y0; x1 <= cmd_x1; y1 <= cmd_y1;
            rgb <= cmd_rgb; err <= 1'b0;
        end else if (state == CHECK) begin
            x1 <= x1c; y1 <= y1c; err <= rej;
            x <= x0; y <= y0;
            row_base <= start_base;
            addr <= start_base + ADDR_BITS'(x0);
        end else if (consume && !last_x) begin
            x <= x + 10'd1;
            addr <= addr + 1'b1;
        end else if (consume && !last_y) begin
            x <= x0;
            y <= y + 9'd1;
            row_base <= row_base + ROW;
            addr <= row_base + ROW + ADDR_BITS'(x0);
        end
    end
endmodule

// File: tb/tb_fb_fill_writer.sv
// tb_fb_fill_writer: directed and randomized fills checked against a raster model
module tb_fb_fill_writer;
    localparam int H = 640, V = 480;
    logic        clock = 1'b0, reset = 1'b1, cmd_valid = 1'b0, fb_stall = 1'b0;
    logic [9:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [8:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic [2:0]  cmd_rgb = '0;
    logic        cmd_ready, fb_we, fb_red, fb_green, fb_blue, busy, done, cmd_err;
    logic [18:0] fb_write_addr;
    int checks = 0, fails = 0;

    fb_fill_writer dut (
        .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_rgb(cmd_rgb),
        .fb_we(fb_we), .fb_stall(fb_stall), .fb_write_addr(fb_write_addr),
        .fb_red(fb_red), .fb_green(fb_green), .fb_blue(fb_blue),
        .busy(busy), .done(done), .cmd_err(cmd_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode: 0 no stall, 1 random stall, 2 three-cycle stall on the second write
    task automatic run(input int x0, input int y0, input int x1, input int y1, input logic [2:0] rgb,
                       input int mode, input int abort_at, input bit pulse);
        int q[$];
        int cx1, cy1, idx, stalls, c, held, cnt_hold;
        bit rej, fin;
        cx1 = (x1 > H - 1) ? H - 1 : x1;
        cy1 = (y1 > V - 1) ? V - 1 : y1;
        rej = (x0 >= H) || (y0 >= V) || (x0 > cx1) || (y0 > cy1);
        if (!rej)
            for (int yy = y0; yy <= cy1; yy++)
                for (int xx = x0; xx <= cx1; xx++) q.push_back(yy * H + xx);
        idx = 0; stalls = 0; c = 0; held = 0; cnt_hold = 0; fin = 0;
        @(negedge clock);
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_x0 = 10'(x0); cmd_y0 = 9'(y0); cmd_x1 = 10'(x1); cmd_y1 = 9'(y1); cmd_rgb = rgb;
        while (!fin && c < q.size() * 5 + 20) begin
            @(negedge clock);
            c++;
            if (c == 1) cmd_valid = 1'b0;
            if (abort_at > 0 && idx == abort_at) begin
                fb_stall = 1'b0;
                #2 reset = 1'b1;
                #1;
                check("abort_we_async", fb_we, 0);
                check("abort_busy_async", busy, 0);
                @(posedge clock);
                @(negedge clock);
                check("abort_no_done", done, 0);
                check("abort_no_we", fb_we, 0);
                reset = 1'b0;
                @(negedge clock);
                check("abort_ready_after", cmd_ready, 1);
                check("abort_busy_after", busy, 0);
                return;
            end
            if (pulse && c == 20) begin
                check("ready_mid_fill", cmd_ready, 0);
                cmd_valid = 1'b1; cmd_x0 = 10'd0; cmd_y0 = 9'd0; cmd_x1 = 10'd1; cmd_y1 = 9'd1;
            end
            if (pulse && c == 21) cmd_valid = 1'b0;
            fb_stall = 1'b0;
            if (fb_we && mode == 1) fb_stall = ($urandom_range(0, 3) == 0);
            if (fb_we && mode == 2 && idx == 1 && held < 3) begin
                fb_stall = 1'b1;
                held++;
            end
            if (fb_we && fb_stall) stalls++;
            if (c == 1) begin
                check("busy_after_accept", busy, 1);
                check("ready_after_accept", cmd_ready, 0);
                check("we_in_check", fb_we, 0);
            end
            if (c == 2) begin
                check("first_we_latency", fb_we, !rej);
                check("reject_done_latency", done, rej);
            end
            if (fb_we) begin
                if (idx < q.size()) begin
                    check("write_addr_rgb", {fb_write_addr, fb_red, fb_green, fb_blue},
                          {19'(q[idx]), rgb});
                    if (mode == 2 && q[idx] == 1923) cnt_hold++;
                    if (!fb_stall) idx++;
                end else check("extra_write", fb_we, 0);
            end
            if (done) begin
                check("done_cycle", c, 2 + q.size() + stalls);
                check("done_err", cmd_err, rej);
                check("write_count", idx, q.size());
                check("we_at_done", fb_we, 0);
                fin = 1;
            end
        end
        fb_stall = 1'b0;
        if (!fin) check("timeout_no_done", fin, 1);
        if (mode == 2) check("hold_1923_cycles", cnt_hold, 4);
        @(negedge clock);
        check("idle_ready", cmd_ready, 1);
        check("idle_done_low", {busy, done, cmd_err}, 0);
    endtask

    initial begin
        int rx0, ry0, rx1, ry1;
        repeat (2) @(negedge clock);
        check("rst_we", fb_we, 0);
        check("rst_addr", fb_write_addr, 0);
        check("rst_rgb", {fb_red, fb_green, fb_blue}, 0);
        check("rst_busy_done_err", {busy, done, cmd_err}, 0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_ready", cmd_ready, 1);
        run(2, 3, 4, 4, 3'b101, 0, 0, 0);
        run(2, 3, 4, 4, 3'b101, 2, 0, 0);
        run(630, 479, 700, 500, 3'b011, 0, 0, 0);
        run(5, 0, 4, 0, 3'b111, 0, 0, 0);
        run(0, 480, 1, 481, 3'b111, 0, 0, 0);
        run(7, 7, 7, 7, 3'b010, 0, 0, 0);
        run(2, 3, 4, 4, 3'b101, 0, 3, 0);
        run(1, 1, 3, 2, 3'b110, 0, 0, 0);
        run(0, 440, 639, 479, 3'b111, 0, 0, 1);
        for (int k = 0; k < 40; k++) begin
            rx0 = $urandom_range(0, 700);
            ry0 = $urandom_range(0, 500);
            rx1 = rx0 + $urandom_range(0, 12) - 2;
            ry1 = ry0 + $urandom_range(0, 6) - 1;
            rx1 = (rx1 < 0) ? 0 : (rx1 > 1023) ? 1023 : rx1;
            ry1 = (ry1 < 0) ? 0 : (ry1 > 511) ? 511 : ry1;
            run(rx0, ry0, rx1, ry1, 3'($urandom_range(0, 7)), 1, 0, 0);
        end
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
